alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test engine for the 32-bit combinational `ALU` (`a`, `b`, `sign`, `sub` in; `p`, `overflow` out). It sits on the driving side of that interface. It generates pseudo-random operand and mode vectors, presents them to the ALU, and compresses every `p`/`overflow` response into a 32-bit MISR signature. It compares the signature with a golden value, so ALU health is checked in silicon or in a long regression without a software reference model.

## Interface
Parameters:
- `NUM_VECTORS`, default 256: vectors per run; legal range 1..65535.
- `SEED`, default 32'h0000_0001: LFSR seed; must be non-zero.
- `GOLDEN_SIG`, default 32'h0000_0000: expected final signature.

Ports:
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run completion until the next accepted `start`.
- `pass`  out  1  signature equalled `GOLDEN_SIG`; valid while `done` is high.
- `signature`  out  32  current MISR contents.
- `alu_a`, `alu_b`  out  32  operands to the ALU; registered.
- `alu_sign`, `alu_sub`  out  1  ALU mode controls; registered.
- `alu_p`  in  32  ALU result.
- `alu_overflow`  in  1  ALU overflow flag.

## Operation
- FSM states are IDLE, DRIVE, CAPTURE and DONE. Reset enters IDLE.
- IDLE or DONE, with `start`=1:
  - Seed the LFSR with `SEED`, clear the MISR to 0 and clear the vector count `i` to 0.
  - Load vector 0 onto the `alu_*` outputs.
  - Clear `done` and `pass`, then go to DRIVE.
- DRIVE: hold the operands (ALU settling cycle), then go to CAPTURE unconditionally.
- CAPTURE:
  - Update the MISR: sig <= {sig[30:0], fb} ^ `alu_p` ^ {31'b0, `alu_overflow`}, where fb = sig[31]^sig[21]^sig[1]^sig[0].
  - If `i`==`NUM_VECTORS`-1, go to DONE. Otherwise advance the LFSR, increment `i`, load vector `i`+1 and go to DRIVE.
- DONE: `done`=1, and `pass` is registered as (final sig == `GOLDEN_SIG`). Hold until `start`.
- LFSR: 32-bit Galois, taps mask 32'h8020_0003, shifting right. Vector 0 uses `SEED` unadvanced.
- Vector `i` is built from the current LFSR state L:
  - a = L
  - b = {L[15:0], L[31:16]} ^ {16'b0, i[15:0]}
  - sign = i[0]
  - sub = i[1]
- `start` is ignored while `busy`=1. `busy`=1 in DRIVE and CAPTURE only.
- Reset mid-run aborts immediately. All outputs return to reset values and the partial signature is discarded.

## Timing
- Reset values are 0 for `busy`, `done`, `pass`, `signature`, `alu_a`, `alu_b`, `alu_sign` and `alu_sub`.
- Each vector takes 2 cycles. If `start` is sampled at edge T:
  - vector `i` operands are valid from edge T+2i;
  - vector `i` is captured at edge T+2i+2;
  - `done`, `pass` and the final `signature` are valid from edge T+2·`NUM_VECTORS`.
- `busy` rises at edge T and falls at edge T+2·`NUM_VECTORS`.
- `signature` updates only on CAPTURE edges.
- `start` held high in DONE immediately restarts the run. Back-to-back runs therefore have no idle cycle.

## Configuration
- The macro is `ALU_BIST_DIRECTED_EN`.
- Defined: vectors 0-3 are fixed corner cases instead of LFSR vectors. The LFSR is not advanced during them, and LFSR vectors start at `i`=4. Total vector count stays `NUM_VECTORS`; runs shorter than 4 vectors truncate the list. The directed cases, as (a, b, sign, sub), are:
  - (7FFF_FFFF, 0000_0001, 1, 0): signed add overflow
  - (8000_0000, 0000_0001, 1, 1): signed sub overflow
  - (FFFF_FFFF, 0000_0001, 0, 0): unsigned carry-out
  - (0000_0000, 0000_0001, 0, 1): unsigned borrow
- Undefined: all vectors come from the LFSR.

## Structure
- Package `alu_bist_pkg` holds:
  - the state enum;
  - `LFSR_TAPS` = 32'h8020_0003;
  - the MISR feedback tap indices;
  - the four directed-vector constants.
- One sub-module, `alu_bist_lfsr`, holds the seedable 32-bit Galois LFSR with `load`, `seed` and `advance` ports. The MISR stays inline.

## Test plan
- Run with `NUM_VECTORS`=1, `SEED`=1, an ALU stub computing p=a+b and overflow=0, and `start` pulsed once:
  - `alu_a`=0000_0001, `alu_b`=0001_0000, sign=0, sub=0;
  - `signature`=0001_0001 and `done`=1 at T+2.
- Same setup with `GOLDEN_SIG`=0001_0001 gives `pass`=1. Forcing the stub's p to 0 gives `signature`=0 and `pass`=0.
- `start` pulsed again at T+3 while `busy` (`NUM_VECTORS`=4): ignored, and `done` still rises exactly at T+8.
- `rst_n`=0 at T+5 of an 8-vector run: the next edge shows all outputs 0 and the FSM in IDLE. A fresh `start` then reproduces the full-run signature of an uninterrupted run.
- With `ALU_BIST_DIRECTED_EN` and a real `ALU` connected: vector 0 presents 7FFF_FFFF, 0000_0001, sign=1, and `alu_overflow`=1 is sampled at T+2. Vector 1 presents 8000_0000 with sub=1.
- With `NUM_VECTORS`=256 and `start` held high: `done` pulses for one cycle between consecutive runs, and both runs give identical signatures.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared types and constants for the ALU BIST engine.
// Rev 1.0
`default_nettype none

package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int MISR_TAP_A = 31;
  localparam int MISR_TAP_B = 21;
  localparam int MISR_TAP_C = 1;
  localparam int MISR_TAP_D = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        sub;
  } vec_t;

  // Corner cases that random vectors almost never hit: both overflow and carry/borrow edges.
  localparam vec_t DIR_ADD_OVF    = {32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
  localparam vec_t DIR_SUB_OVF    = {32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1};
  localparam vec_t DIR_CARRY_OUT  = {32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
  localparam vec_t DIR_BORROW     = {32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1};

  function automatic vec_t lfsr_vec(input logic [31:0] l, input logic [15:0] n);
    vec_t v;
    v.a    = l;
    v.b    = {l[15:0], l[31:16]} ^ {16'b0, n};
    v.sign = n[0];
    v.sub  = n[1];
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bist_lfsr.sv
// alu_bist_lfsr: seedable 32-bit right-shifting Galois LFSR; next_value is the advanced state.
// Rev 1.0
`default_nettype none

module alu_bist_lfsr
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value,
  output logic [31:0] next_value
);

  always_comb begin
    next_value = value >> 1;
    if (value[0]) next_value = next_value ^ LFSR_TAPS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       value <= 32'd0;
    else if (load)    value <= seed;
    else if (advance) value <= next_value;
  end

endmodule

`default_nettype wire

// File: rtl/alu_bist.sv
// alu_bist: pseudo-random ALU self-test with 32-bit MISR signature compaction.
// Optional macro ALU_BIST_DIRECTED_EN replaces vectors 0-3 with fixed corner cases. Rev 1.0
`default_nettype none

module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_sign,
  output logic        alu_sub,
  input  logic [31:0] alu_p,
  input  logic        alu_overflow
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  state_t      state;
  logic [15:0] idx;
  logic [15:0] idx_next;
  logic [31:0] lfsr_value;
  logic [31:0] lfsr_next;
  logic [31:0] l_next;
  logic [31:0] sig_next;
  logic        fb;
  logic        last;
  logic        accept;
  logic        lfsr_adv;
  vec_t        vec_first;
  vec_t        vec_next;

`ifdef ALU_BIST_DIRECTED_EN
  // The LFSR only starts stepping once the directed prefix is exhausted.
  function automatic logic on_lfsr(input logic [15:0] n);
    return n >= 16'd4;
  endfunction

  function automatic vec_t pick_vec(input logic [31:0] l, input logic [15:0] n);
    if (n >= 16'd4) return lfsr_vec(l, n);
    case (n[1:0])
      2'd0:    return DIR_ADD_OVF;
      2'd1:    return DIR_SUB_OVF;
      2'd2:    return DIR_CARRY_OUT;
      default: return DIR_BORROW;
    endcase
  endfunction
`else
  function automatic logic on_lfsr(input logic [15:0] n);
    return n == n;
  endfunction

  function automatic vec_t pick_vec(input logic [31:0] l, input logic [15:0] n);
    return lfsr_vec(l, n);
  endfunction
`endif

  always_comb begin
    fb        = signature[MISR_TAP_A] ^ signature[MISR_TAP_B] ^
                signature[MISR_TAP_C] ^ signature[MISR_TAP_D];
    sig_next  = {signature[30:0], fb} ^ alu_p ^ {31'b0, alu_overflow};
    last      = (idx == LAST_IDX);
    accept    = start && (state == IDLE || state == DONE);
    idx_next  = idx + 16'd1;
    lfsr_adv  = (state == CAPTURE) && !last && on_lfsr(idx);
    l_next    = lfsr_adv ? lfsr_next : lfsr_value;
    vec_first = pick_vec(SEED, 16'd0);
    vec_next  = pick_vec(l_next, idx_next);
  end

  alu_bist_lfsr u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .seed       (SEED),
    .advance    (lfsr_adv),
    .value      (lfsr_value),
    .next_value (lfsr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 32'd0;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      alu_sign  <= 1'b0;
      alu_sub   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            signature <= 32'd0;
            idx       <= 16'd0;
            alu_a     <= vec_first.a;
            alu_b     <= vec_first.b;
            alu_sign  <= vec_first.sign;
            alu_sub   <= vec_first.sub;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: state <= CAPTURE;
        CAPTURE: begin
          signature <= sig_next;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == GOLDEN_SIG);
            state <= DONE;
          end else begin
            idx      <= idx_next;
            alu_a    <= vec_next.a;
            alu_b    <= vec_next.b;
            alu_sign <= vec_next.sign;
            alu_sub  <= vec_next.sub;
            state    <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_bist.sv
// tb_alu_bist: randomized self-checking bench for alu_bist against a vector/MISR reference model.
// Rev 1.0
`default_nettype none

module tb_alu_bist;

  localparam int          N_MAIN    = 8;
  localparam logic [31:0] SEED_MAIN = 32'hC0DE_1235;
  localparam logic [31:0] GOLD_MAIN = 32'h0000_0000;
  localparam logic [31:0] GOLD_ONE  = 32'h0001_0001;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start_one;
  logic [31:0] mask;
  logic        zero, zero_one;

  logic        busy, done, pass, alu_sign, alu_sub, alu_overflow;
  logic [31:0] signature, alu_a, alu_b, alu_p;
  logic        busy1, done1, pass1, sign1, sub1;
  logic [31:0] sig1, a1, b1, p1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: result and overflow from wide integer arithmetic.
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic sign, input logic sub);
    longint r;
    logic   ovf;
    if (sign) begin
      r   = sub ? longint'($signed(a)) - longint'($signed(b))
                : longint'($signed(a)) + longint'($signed(b));
      ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end else begin
      r   = sub ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
      ovf = (r < 0) || (r > longint'(32'hFFFF_FFFF));
    end
    return {ovf, r[31:0]};
  endfunction

  logic [32:0] alu_res;
  assign alu_res      = ref_alu(alu_a, alu_b, alu_sign, alu_sub);
  assign alu_p        = zero ? 32'd0 : alu_res[31:0] ^ mask;
  assign alu_overflow = zero ? 1'b0 : alu_res[32];
  assign p1           = zero_one ? 32'd0 : a1 + b1;

  alu_bist #(.NUM_VECTORS(N_MAIN), .SEED(SEED_MAIN), .GOLDEN_SIG(GOLD_MAIN)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .alu_a(alu_a), .alu_b(alu_b), .alu_sign(alu_sign),
    .alu_sub(alu_sub), .alu_p(alu_p), .alu_overflow(alu_overflow)
  );

  alu_bist #(.NUM_VECTORS(1), .SEED(32'h0000_0001), .GOLDEN_SIG(GOLD_ONE)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_one), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .alu_a(a1), .alu_b(b1), .alu_sign(sign1),
    .alu_sub(sub1), .alu_p(p1), .alu_overflow(1'b0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] galois(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] p, input logic o);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ p ^ {31'b0, o};
  endfunction

  // Vector i of a run, derived from the seed by walking the LFSR sequence.
  task automatic gen_vectors(input logic [31:0] seed, input int n,
                             output logic [31:0] va[], output logic [31:0] vb[],
                             output logic vs[], output logic vu[]);
    logic [31:0] l;
    logic [15:0] k;
    logic [31:0] da[4];
    logic [31:0] db[4];
    logic        ds[4];
    logic        du[4];
    da = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    db = '{32'h1, 32'h1, 32'h1, 32'h1};
    ds = '{1'b1, 1'b1, 1'b0, 1'b0};
    du = '{1'b0, 1'b1, 1'b0, 1'b1};
    va = new[n]; vb = new[n]; vs = new[n]; vu = new[n];
    l = seed;
    for (int i = 0; i < n; i++) begin
      k = 16'(i);
`ifdef ALU_BIST_DIRECTED_EN
      if (i < 4) begin
        va[i] = da[i]; vb[i] = db[i]; vs[i] = ds[i]; vu[i] = du[i];
        continue;
      end
`endif
      va[i] = l;
      vb[i] = {l[15:0], l[31:16]} ^ {16'b0, k};
      vs[i] = k[0];
      vu[i] = k[1];
      l = galois(l);
    end
  endtask

  task automatic run_main(input bit poke, input bit hold);
    logic [31:0] va[], vb[];
    logic        vs[], vu[];
    logic [31:0] sig, p;
    logic [32:0] r;
    gen_vectors(SEED_MAIN, N_MAIN, va, vb, vs, vu);
    sig = 32'd0;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i < N_MAIN; i++) begin
      check_val($sformatf("vec%0d_a", i), alu_a, va[i]);
      check_val($sformatf("vec%0d_b", i), alu_b, vb[i]);
      check_val($sformatf("vec%0d_mode", i), {30'b0, alu_sign, alu_sub}, {30'b0, vs[i], vu[i]});
      check_val($sformatf("vec%0d_busy_done", i), {30'b0, busy, done}, 32'd2);
      if (poke && i == 1) start = 1'b1;
      step();
      if (poke && i == 1 && !hold) start = 1'b0;
      check_val($sformatf("vec%0d_sig_hold", i), signature, sig);
      step();
      r = ref_alu(va[i], vb[i], vs[i], vu[i]);
      p = zero ? 32'd0 : r[31:0] ^ mask;
      sig = misr(sig, p, zero ? 1'b0 : r[32]);
    end
    check_val("end_busy_done", {30'b0, busy, done}, 32'd1);
    check_val("end_signature", signature, sig);
    check_val("end_pass", {31'b0, pass}, {31'b0, sig == GOLD_MAIN});
  endtask

  initial begin
    logic [31:0] va[], vb[];
    logic        vs[], vu[];
    logic [31:0] e;
    rst_n = 1'b0; start = 1'b0; start_one = 1'b0;
    mask = 32'd0; zero = 1'b0; zero_one = 1'b0;
    repeat (3) step();
    check_val("rst_status", {29'b0, busy, done, pass}, 32'd0);
    check_val("rst_sig", signature, 32'd0);
    check_val("rst_a", alu_a, 32'd0);
    check_val("rst_b", alu_b, 32'd0);
    check_val("rst_mode", {30'b0, alu_sign, alu_sub}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single-vector instance with an adder stub, then with p forced to zero.
    gen_vectors(32'h0000_0001, 1, va, vb, vs, vu);
    e = va[0] + vb[0];
    for (int pass_i = 0; pass_i < 2; pass_i++) begin
      zero_one  = (pass_i == 1);
      start_one = 1'b1;
      step();
      start_one = 1'b0;
      check_val("one_a", a1, va[0]);
      check_val("one_b", b1, vb[0]);
      check_val("one_mode", {30'b0, sign1, sub1}, {30'b0, vs[0], vu[0]});
      step(); step();
      check_val("one_done", {30'b0, busy1, done1}, 32'd1);
      check_val("one_sig", sig1, zero_one ? 32'd0 : e);
      check_val("one_pass", {31'b0, pass1}, {31'b0, !zero_one && e == GOLD_ONE});
      repeat ($urandom_range(0, 2)) step();
    end
    zero_one = 1'b0;

    // Randomized response masks, idle gaps and ignored start pokes.
    for (int run = 0; run < 5; run++) begin
      mask = (run == 0) ? 32'd0 : $urandom;
      zero = (run == 4);
      run_main(($urandom & 1) == 1, 1'b0);
      repeat ($urandom_range(0, 3)) step();
      check_val("idle_done_hold", {30'b0, busy, done}, 32'd1);
    end
    zero = 1'b0;

    // Abort mid-run: reset sampled at T+5.
    mask = $urandom;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    check_val("abort_status", {29'b0, busy, done, pass}, 32'd0);
    check_val("abort_sig", signature, 32'd0);
    check_val("abort_ops", alu_a | alu_b | {30'b0, alu_sign, alu_sub}, 32'd0);
    rst_n = 1'b1;
    step();
    run_main(1'b0, 1'b0);

    // Start held high: back-to-back runs with a single-cycle done pulse.
    mask = $urandom;
    run_main(1'b0, 1'b1);
    run_main(1'b0, 1'b1);
    start = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
